// File: rtl/md6_uart_pkg.sv
// ---------------------------------------------------------------------------
// md6_uart_pkg
// Definitions shared by the MD6 UART link (TX and RX sides).
//   CLKS_PER_BIT_DEF : clocks per UART bit (100 MHz / 9600 baud)
//   NUM_BYTES_DEF    : digest bytes per transfer (512 / 8)
//   state_t          : transmit FSM states
// ---------------------------------------------------------------------------
package md6_uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 10417;
    localparam int unsigned NUM_BYTES_DEF    = 64;

    // S_NEXT_BYTE is a zero-length handoff: the next byte is loaded on the
    // final tick of S_STOP, so no cycle is ever spent in it.
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_NEXT_BYTE,
        S_DONE
    } state_t;

endpackage

// File: rtl/md6_hash_uart_tx_byte.sv
// ---------------------------------------------------------------------------
// uart_tx_byte
// Single-byte 8N1 serializer: start bit, 8 data bits LSB first, stop bit.
// Ports:
//   clk   in  1  system clock
//   reset in  1  asynchronous, active-high
//   start in  1  load data and begin a frame (honoured while ready=1)
//   data  in  8  byte to send, sampled when start & ready
//   TxD   out 1  serial line, idle high
//   ready out 1  can accept a byte this cycle (idle, or last tick of stop)
// ---------------------------------------------------------------------------
import md6_uart_pkg::*;

module uart_tx_byte #(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       TxD,
    output logic       ready
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    state_t        r_state;
    logic [CW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_txd;

    logic w_tick;
    logic w_load;

    assign w_tick = (r_state != S_IDLE) && (r_baud == BAUD_LAST);
    // Accepting on the last stop tick lets frames run back to back.
    assign ready  = (r_state == S_IDLE) || ((r_state == S_STOP) && w_tick);
    assign w_load = start && ready;
    assign TxD    = r_txd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
        end else begin
            if (w_load || w_tick || (r_state == S_IDLE))
                r_baud <= '0;
            else
                r_baud <= r_baud + 1'b1;

            if (w_load) begin
                r_shift <= data;
                r_txd   <= 1'b0;
                r_state <= S_START;
            end else begin
                case (r_state)
                    S_START: if (w_tick) begin
                        r_txd   <= r_shift[0];
                        r_bit   <= '0;
                        r_state <= S_DATA;
                    end
                    S_DATA: if (w_tick) begin
                        if (r_bit == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_shift <= r_shift >> 1;
                            r_txd   <= r_shift[1];
                            r_bit   <= r_bit + 1'b1;
                        end
                    end
                    S_STOP: if (w_tick) begin
                        r_state <= S_IDLE;
                    end
                    S_IDLE: r_txd <= 1'b1;
                    default: begin
                        r_txd   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/md6_hash_uart_tx.sv
// ---------------------------------------------------------------------------
// md6_hash_uart_tx
// Sends the 512-bit MD6 digest over UART TxD, most-significant byte first,
// as 64 back-to-back 8N1 frames. Armed by done_MD6, started by button_tx.
// Ports:
//   clk       in  1    system clock, rising edge
//   reset     in  1    asynchronous, active-high
//   button_tx in  1    raw push-button, asynchronous to clk
//   hash      in  512  MD6 digest, valid while done_MD6=1
//   done_MD6  in  1    digest ready (level)
//   TxD       out 1    UART serial out, idle high
//   busy_tx   out 1    high from first start bit to end of last stop bit
//   done_tx   out 1    high after last byte until next start or reset
// ---------------------------------------------------------------------------
import md6_uart_pkg::*;

module md6_hash_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned NUM_BYTES    = NUM_BYTES_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         button_tx,
    input  logic [511:0] hash,
    input  logic         done_MD6,
    output logic         TxD,
    output logic         busy_tx,
    output logic         done_tx
);

    localparam int unsigned BW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [BW-1:0] BYTE_LAST = BW'(NUM_BYTES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_sync3;
    state_t        r_state;
    logic [511:0]  r_hold;
    logic [BW-1:0] r_byte;
    logic          r_busy;
    logic          r_done;

    logic          w_edge;
    logic          w_start;
    logic          w_ser_ready;
    logic          w_ser_start;
    logic          w_last_byte;

    // Button synchronizer plus one delay flop for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= button_tx;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_edge      = r_sync2 && !r_sync3;
    assign w_start     = w_edge && done_MD6 && (r_state == S_IDLE);
    assign w_last_byte = (r_byte == BYTE_LAST);

    // The holding register shifts left as bytes are launched, so the byte
    // presented to the serializer is always the top of r_hold.
    assign w_ser_start = (r_state == S_START) ||
                         ((r_state == S_DATA) && w_ser_ready && !w_last_byte);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_hold  <= '0;
            r_byte  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_hold  <= hash;
                    r_byte  <= '0;
                    r_state <= S_START;
                end
                S_START: begin
                    r_hold  <= {r_hold[503:0], 8'h00};
                    r_busy  <= 1'b1;
                    r_done  <= 1'b0;
                    r_state <= S_DATA;
                end
                S_DATA: if (w_ser_ready) begin
                    if (w_last_byte) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_hold <= {r_hold[503:0], 8'h00};
                        r_byte <= r_byte + 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx_byte (
        .clk   (clk),
        .reset (reset),
        .start (w_ser_start),
        .data  (r_hold[511:504]),
        .TxD   (TxD),
        .ready (w_ser_ready)
    );

    assign busy_tx = r_busy;
    assign done_tx = r_done;

endmodule
